rr_credit_dispatcher: RTL

RR_CREDIT_DISPATCHER -- requirements
Module: rr_credit_dispatcher

---
 rtl/rr_credit_dispatcher.sv | 98 +++++++++
 1 files changed

// File: rtl/rr_credit_dispatcher.sv
// Round-robin dispatcher: routes upstream words to the next port that
// still holds downstream credit, one registered dispatch per cycle.
module rr_credit_dispatcher #(
  parameter int PORTS   = 8,
  parameter int DWIDTH  = 32,
  parameter int CREDITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DWIDTH-1:0]        s_data,
  input  logic [PORTS-1:0]         credit_return,
  output logic [PORTS-1:0]         m_valid,
  output logic [DWIDTH-1:0]        m_data,
  output logic [$clog2(PORTS)-1:0] m_port,
  output logic                     credit_err
);

  localparam int PW = $clog2(PORTS);
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] FULL = CW'(CREDITS);

  logic [CW-1:0]    cnt [PORTS];
  logic [PORTS-1:0] ptr;
  logic [PORTS-1:0] elig;
  logic [PORTS-1:0] full;
  logic [PORTS-1:0] above;
  logic [PORTS-1:0] win;
  logic [PORTS-1:0] take;
  logic [PW-1:0]    win_idx;
  logic             fire;
  logic             ovf;

  always_comb begin
    elig = '0;
    full = '0;
    for (int i = 0; i < PORTS; i++) begin
      elig[i] = cnt[i] != '0;
      full[i] = cnt[i] == FULL;
    end
  end

  // ptr-1 masks every port below the pointer; fall back to the
  // whole set when nothing at or above it is eligible (wrap).
  always_comb begin
    above = elig & ~(ptr - PORTS'(1));
    if (|above)
      win = above & (~above + PORTS'(1));
    else
      win = elig & (~elig + PORTS'(1));
  end

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < PORTS; i++)
      if (win[i]) win_idx = PW'(i);
  end

  assign s_ready = (|elig) & ~rst;
  assign fire    = s_valid & s_ready;
  assign take    = fire ? win : '0;
  assign ovf     = |(credit_return & full & ~take);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= PORTS'(1);
      m_valid    <= '0;
      m_data     <= '0;
      m_port     <= '0;
      credit_err <= 1'b0;
    end else begin
      m_valid <= take;
      if (fire) begin
        m_data <= s_data;
        m_port <= win_idx;
        ptr    <= {win[PORTS-2:0], win[PORTS-1]};
      end
      if (ovf) credit_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PORTS; i++)
        cnt[i] <= FULL;
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        unique case ({take[i], credit_return[i]})
          2'b10:   cnt[i] <= cnt[i] - CW'(1);
          2'b01:   if (!full[i]) cnt[i] <= cnt[i] + CW'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

endmodule
